// File: rtl/wb_sevenseg_pkg.sv
// Shared register map, CTRL reset value and segment encoding for the
// wb_sevenseg_mux display scanner.
package wb_sevenseg_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_DP     = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  localparam logic [31:0] CTRL_RST = 32'h0000_00F1;

  // Active-low a..g on bits 0..6; element 0 is hex digit 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module sevenseg_decode
  import wb_sevenseg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/wb_sevenseg_mux.sv
// Wishbone slave scanning a 4-digit common-anode seven-segment display.
// Optional leading-zero blanking: define WB_SEVENSEG_BLANK_LEADING_ZEROS_EN.
module wb_sevenseg_mux
  import wb_sevenseg_pkg::*;
#(
  parameter int clk_freq   = 50000000,
  parameter int refresh_hz = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int DIV = clk_freq / (4 * refresh_hz);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] PS_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_ps;
  logic [1:0]    r_idx;
  logic [15:0]   r_data;
  logic [3:0]    r_dp;
  logic          r_en;
  logic [3:0]    r_mask;
  logic          r_ack;
  logic [31:0]   r_dat_o;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp_n;

  logic          w_req;
  logic          w_wr;
  logic          w_blz;
  logic          w_blank;
  logic [31:0]   w_rdata;
  logic [3:0]    w_nib;
  logic [6:0]    w_dec;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic          w_unused;

  assign w_req    = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr     = w_req & wb_we_i;
  assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

`ifdef WB_SEVENSEG_BLANK_LEADING_ZEROS_EN
  logic r_blz;

  always_ff @(posedge clk) begin
    if (reset)
      r_blz <= CTRL_RST[1];
    else if (w_wr && reg_e'(wb_adr_i[3:2]) == REG_CTRL && wb_sel_i[0])
      r_blz <= wb_dat_i[1];
  end

  assign w_blz = r_blz;
`else
  assign w_blz = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (reg_e'(wb_adr_i[3:2]))
      REG_DATA:   w_rdata = {16'h0, r_data};
      REG_DP:     w_rdata = {28'h0, r_dp};
      REG_CTRL:   w_rdata = {24'h0, r_mask, 2'b00, w_blz, r_en};
      REG_STATUS: w_rdata = {30'h0, r_idx};
      default:    w_rdata = '0;
    endcase
  end

  assign w_nib = r_data[{r_idx, 2'b00} +: 4];

  sevenseg_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // A digit is leading-zero blank when it and every higher nibble are zero.
  assign w_blank = w_blz && (r_idx != 2'd0) && ((r_data >> {r_idx, 2'b00}) == 16'h0);

  always_comb begin
    w_an  = '1;
    w_seg = '1;
    w_dp  = 1'b1;
    if (r_en && r_mask[r_idx]) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = w_blank ? '1 : w_dec;
      w_dp  = ~r_dp[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps    <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_dp    <= '0;
      r_en    <= CTRL_RST[0];
      r_mask  <= CTRL_RST[7:4];
      r_ack   <= 1'b0;
      r_dat_o <= '0;
      r_an    <= '1;
      r_seg   <= '1;
      r_dp_n  <= 1'b1;
    end else begin
      r_ack   <= w_req;
      r_dat_o <= w_req ? w_rdata : '0;
      if (r_ps == PS_LAST) begin
        r_ps  <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_ps <= r_ps + 1'b1;
      end
      if (w_wr) begin
        case (reg_e'(wb_adr_i[3:2]))
          REG_DATA: begin
            if (wb_sel_i[0]) r_data[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) r_data[15:8] <= wb_dat_i[15:8];
          end
          REG_DP: if (wb_sel_i[0]) r_dp <= wb_dat_i[3:0];
          REG_CTRL: begin
            if (wb_sel_i[0]) begin
              r_en   <= wb_dat_i[0];
              r_mask <= wb_dat_i[7:4];
            end
          end
          default: ;
        endcase
      end
      r_an   <= w_an;
      r_seg  <= w_seg;
      r_dp_n <= w_dp;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat_o;
  assign an       = r_an;
  assign seg      = r_seg;
  assign dp       = r_dp_n;

endmodule

// File: tb/tb_wb_sevenseg_mux.sv
// Self-checking bench for wb_sevenseg_mux (DIV = 400/(4*25) = 4).
module tb_wb_sevenseg_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic        wb_ack_o;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_en;
  logic [3:0]  m_mask;
  logic        m_blz;

  logic [6:0] SEG_REF [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  wb_sevenseg_mux #(.clk_freq(400), .refresh_hz(25)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // Number of non-reset rising edges since reset was last released.
  always @(posedge clk) cyc_n <= reset ? 0 : cyc_n + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int scan_idx(input int k);
    return ((k - 1) / 4) % 4;
  endfunction

  // Expected {an, seg, dp} at the falling edge after rising edge k.
  function automatic logic [11:0] exp_pins(input int k);
    int i;
    logic [3:0] a;
    logic [6:0] s;
    logic [3:0] nib;
    logic [15:0] hi;
    if (k == 0) return {4'hF, 7'h7F, 1'b1};
    i = scan_idx(k);
    if (!m_en || !m_mask[i]) return {4'hF, 7'h7F, 1'b1};
    hi  = m_data >> (4 * i);
    nib = hi[3:0];
    s   = (m_blz && i != 0 && hi == 16'h0) ? 7'h7F : SEG_REF[nib];
    a   = 4'hF;
    a[i] = 1'b0;
    return {a, s, ~m_dp[i]};
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a, input int k);
    case (a)
      2'd0:    return {16'h0, m_data};
      2'd1:    return {28'h0, m_dp};
      2'd2:    return {24'h0, m_mask, 2'b00, m_blz, m_en};
      default: return 32'(scan_idx(k));
    endcase
  endfunction

  function automatic void model_reset();
    m_data = '0; m_dp = '0; m_en = 1'b1; m_mask = 4'hF; m_blz = 1'b0;
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
    case (a)
      2'd0: begin
        if (sel[0]) m_data[7:0]  = d[7:0];
        if (sel[1]) m_data[15:8] = d[15:8];
      end
      2'd1: if (sel[0]) m_dp = d[3:0];
      2'd2: if (sel[0]) begin
        m_en   = d[0];
        m_mask = d[7:4];
`ifdef WB_SEVENSEG_BLANK_LEADING_ZEROS_EN
        m_blz  = d[1];
`endif
      end
      default: ;
    endcase
  endfunction

  // Single access: ack is expected on the first edge after stb is raised.
  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] rd, output logic ack, output int k);
    logic [31:0] adr;
    adr = $urandom;
    adr[3:2] = a;
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd = wb_dat_o; ack = wb_ack_o; k = cyc_n;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (we) model_write(a, d, sel);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, wb_ack_o, wb_dat_o} !== {4'hF, 7'h7F, 1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_state got an=%h seg=%h dp=%b ack=%b dat=%h need F/7F/1/0/0", an, seg, dp, wb_ack_o, wb_dat_o);
    end
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({an, seg, dp} !== {4'hE, 7'h40, 1'b1}) begin
      n_bad++;
      $display("FAIL first_digit got an=%h seg=%h dp=%b need E/40/1", an, seg, dp);
    end
  endtask

  task automatic test_idle();
    logic [11:0] e;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e = exp_pins(cyc_n); n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_bad++; $display("FAIL idle_scan k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic test_data_sel();
    logic [31:0] rd; logic ack; int k; logic [11:0] e;
    bus(1'b1, 2'd0, 32'h0000_1234, 4'b0011, rd, ack, k);
    n_cmp++;
    if (ack !== 1'b1) begin n_bad++; $display("FAIL data_write_ack got=%b need=1", ack); end
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      e = exp_pins(cyc_n); n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_bad++; $display("FAIL data1234_pins k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
      end
    end
    bus(1'b0, 2'd0, 32'h0, 4'hF, rd, ack, k);
    n_cmp++;
    if (rd !== 32'h0000_1234) begin n_bad++; $display("FAIL data_readback got=%h need=00001234", rd); end
    bus(1'b1, 2'd0, 32'hFFFF_FFAB, 4'b0001, rd, ack, k);
    bus(1'b0, 2'd0, 32'h0, 4'hF, rd, ack, k);
    n_cmp++;
    if (rd !== 32'h0000_12AB) begin n_bad++; $display("FAIL data_lane0 got=%h need=000012AB", rd); end
  endtask

  task automatic test_ctrl_mask();
    logic [31:0] rd; logic ack; int k; logic [11:0] e;
    bus(1'b1, 2'd2, 32'h0000_0050, 4'hF, rd, ack, k);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      e = exp_pins(cyc_n); n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_bad++; $display("FAIL mask50_pins k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
      end
    end
    bus(1'b1, 2'd2, 32'h0, 4'hF, rd, ack, k);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); n_cmp++;
      if (an !== 4'hF) begin n_bad++; $display("FAIL ctrl_off_an k=%0d got=%h need=F", cyc_n, an); end
    end
    bus(1'b1, 2'd2, 32'h0000_00F1, 4'b0001, rd, ack, k);
  endtask

  task automatic test_dp_status();
    logic [31:0] rd; logic ack; int k; logic [11:0] e;
    bus(1'b1, 2'd1, 32'h0000_0004, 4'hF, rd, ack, k);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      e = exp_pins(cyc_n); n_cmp++;
      if ({an, seg, dp} !== e || (dp === 1'b0 && an !== 4'b1011)) begin
        n_bad++; $display("FAIL dp_pins k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
      end
    end
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus(1'b0, 2'd3, 32'h0, 4'hF, rd, ack, k);
      n_cmp++;
      if (rd !== exp_read(2'd3, k) || an !== ~(4'b0001 << rd[1:0])) begin
        n_bad++; $display("FAIL status_read got=%h an=%h need=%h", rd, an, exp_read(2'd3, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic ack; int k; logic [2:0] acks;
    @(negedge clk);
    wb_adr_i = 32'h0000_0000; wb_dat_i = 32'h0000_5A5A; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk); acks[0] = wb_ack_o; wb_dat_i = 32'h0000_C3D7;
    @(negedge clk); acks[1] = wb_ack_o;
    @(negedge clk); acks[2] = wb_ack_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    model_write(2'd0, 32'h0000_C3D7, 4'hF);
    n_cmp++;
    if (acks !== 3'b101) begin n_bad++; $display("FAIL b2b_ack_pattern got=%b need=101", acks); end
    bus(1'b0, 2'd0, 32'h0, 4'hF, rd, ack, k);
    n_cmp++;
    if (rd !== 32'h0000_C3D7) begin n_bad++; $display("FAIL b2b_readback got=%h need=0000C3D7", rd); end
    @(negedge clk); n_cmp++;
    if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL ack_single_cycle got=%b need=0", wb_ack_o); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; logic ack; int k; logic [1:0] a; logic [3:0] sel; logic [11:0] e;
    for (int it = 0; it < 16; it++) begin
      a = 2'($urandom_range(0, 3)); d = $urandom; sel = 4'($urandom);
      if (a == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      bus(1'b1, a, d, sel, rd, ack, k);
      bus(1'b0, a, 32'h0, 4'hF, rd, ack, k);
      n_cmp++;
      if (rd !== exp_read(a, k)) begin
        n_bad++; $display("FAIL rand_read reg=%0d got=%h need=%h", a, rd, exp_read(a, k));
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        e = exp_pins(cyc_n); n_cmp++;
        if ({an, seg, dp} !== e) begin
          n_bad++; $display("FAIL rand_pins k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
        end
      end
    end
  endtask

  task automatic test_blank();
    logic [31:0] rd; logic ack; int k; logic [11:0] e;
    bus(1'b1, 2'd1, 32'h0, 4'hF, rd, ack, k);
    bus(1'b1, 2'd2, 32'h0000_00F3, 4'hF, rd, ack, k);
    bus(1'b1, 2'd0, 32'h0000_0012, 4'hF, rd, ack, k);
    bus(1'b0, 2'd2, 32'h0, 4'hF, rd, ack, k);
    n_cmp++;
    if (rd !== exp_read(2'd2, k)) begin n_bad++; $display("FAIL blank_ctrl_read got=%h need=%h", rd, exp_read(2'd2, k)); end
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      e = exp_pins(cyc_n); n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_bad++; $display("FAIL blank12_pins k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
      end
    end
    bus(1'b1, 2'd0, 32'h0, 4'hF, rd, ack, k);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      e = exp_pins(cyc_n); n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_bad++; $display("FAIL blank0_pins k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic ack; int k; logic [11:0] e;
    bus(1'b1, 2'd0, 32'h0000_9E7B, 4'hF, rd, ack, k);
    bus(1'b1, 2'd1, 32'h0000_000F, 4'hF, rd, ack, k);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, wb_ack_o, wb_dat_o} !== {4'hF, 7'h7F, 1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL midscan_reset got an=%h seg=%h dp=%b need F/7F/1", an, seg, dp);
    end
    model_reset();
    reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      e = exp_pins(cyc_n); n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_bad++; $display("FAIL post_reset_pins k=%0d got=%h need=%h", cyc_n, {an, seg, dp}, e);
      end
    end
    bus(1'b0, 2'd2, 32'h0, 4'hF, rd, ack, k);
    n_cmp++;
    if (rd !== 32'h0000_00F1) begin n_bad++; $display("FAIL ctrl_reset_value got=%h need=000000F1", rd); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_data_sel();
    test_ctrl_mask();
    test_dp_status();
    test_back_to_back();
    test_random();
    test_blank();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
